// File: rtl/piso_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | piso_serializer                                                            |
// | Parallel-in/serial-out shifter with a one-word holding buffer, bit-tick    |
// | enable and per-bit valid/first/last markers.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             so,
  output logic             so_valid,
  output logic             so_first,
  output logic             so_last,
  output logic             busy
);

  localparam int              c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [WIDTH-1:0]   r_sh_data;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_active;
  logic [WIDTH-1:0]   r_hold_data;
  logic               r_hold_full;
  logic               r_so;
  logic               r_so_valid;
  logic               r_so_first;
  logic               r_so_last;

  logic               w_accept;
  logic               w_tick;
  logic               w_last_tick;
  logic               w_next_bit;
  logic [WIDTH-1:0]   w_shifted;

  assign w_accept    = in_valid & ~r_hold_full;
  assign w_tick      = shift_en & r_active;
  assign w_last_tick = w_tick & (r_cnt == c_cnt_last);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_next_bit = r_sh_data[WIDTH-1];
      assign w_shifted  = {r_sh_data[WIDTH-2:0], IDLE_BIT};
    end else begin : g_lsb_first
      assign w_next_bit = r_sh_data[0];
      assign w_shifted  = {IDLE_BIT, r_sh_data[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_data   <= '0;
      r_cnt       <= '0;
      r_active    <= 1'b0;
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
      r_so        <= IDLE_BIT;
      r_so_valid  <= 1'b0;
      r_so_first  <= 1'b0;
      r_so_last   <= 1'b0;
    end else if (clear) begin
      r_cnt       <= '0;
      r_active    <= 1'b0;
      r_hold_full <= 1'b0;
      r_so        <= IDLE_BIT;
      r_so_valid  <= 1'b0;
      r_so_first  <= 1'b0;
      r_so_last   <= 1'b0;
    end else begin
      if (shift_en) begin
        if (r_active) begin
          r_so       <= w_next_bit;
          r_so_valid <= 1'b1;
          r_so_first <= (r_cnt == '0);
          r_so_last  <= (r_cnt == c_cnt_last);
          r_sh_data  <= w_shifted;
          r_cnt      <= r_cnt + c_cnt_one;
        end else begin
          r_so       <= IDLE_BIT;
          r_so_valid <= 1'b0;
          r_so_first <= 1'b0;
          r_so_last  <= 1'b0;
        end
      end

      // End of word: refill from the buffer, else go idle (an accept below may override)
      if (w_last_tick) begin
        if (r_hold_full) begin
          r_sh_data   <= r_hold_data;
          r_cnt       <= '0;
          r_hold_full <= 1'b0;
        end else begin
          r_active <= 1'b0;
          r_cnt    <= '0;
        end
      end

      if (w_accept) begin
        if (!r_active || w_last_tick) begin
          r_sh_data <= in_data;
          r_cnt     <= '0;
          r_active  <= 1'b1;
        end else begin
          r_hold_data <= in_data;
          r_hold_full <= 1'b1;
        end
      end
    end
  end

  assign in_ready = ~r_hold_full;
  assign busy     = r_active | r_hold_full;
  assign so       = r_so;
  assign so_valid = r_so_valid;
  assign so_first = r_so_first;
  assign so_last  = r_so_last;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_piso_serializer                                                         |
// | Randomized bench: MSB-first/idle-0 and LSB-first/idle-1 instances driven   |
// | in parallel and compared against a word-queue reference model.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       shift_en = 1'b0;

  logic       in_ready0, so0, so_valid0, so_first0, so_last0, busy0;
  logic       in_ready1, so1, so_valid1, so_first1, so_last1, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of words not yet fully emitted and the next bit position
  int         m_n  [2];
  int         m_bp [2];
  logic [7:0] m_w  [2][2];
  logic       e_so [2];
  logic       e_v  [2];
  logic       e_f  [2];
  logic       e_l  [2];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .shift_en(shift_en), .so(so0), .so_valid(so_valid0),
    .so_first(so_first0), .so_last(so_last0), .busy(busy0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .shift_en(shift_en), .so(so1), .so_valid(so_valid1),
    .so_first(so_first1), .so_last(so_last1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_idle(input int i);
    m_n[i]  = 0;
    m_bp[i] = 0;
    e_so[i] = (i == 1);
    e_v[i]  = 1'b0;
    e_f[i]  = 1'b0;
    e_l[i]  = 1'b0;
  endtask

  task automatic check_all();
    chk("so0",       32'(so0),       32'(e_so[0]));
    chk("so_valid0", 32'(so_valid0), 32'(e_v[0]));
    chk("so_first0", 32'(so_first0), 32'(e_f[0]));
    chk("so_last0",  32'(so_last0),  32'(e_l[0]));
    chk("in_ready0", 32'(in_ready0), 32'(m_n[0] < 2));
    chk("busy0",     32'(busy0),     32'(m_n[0] > 0));
    chk("so1",       32'(so1),       32'(e_so[1]));
    chk("so_valid1", 32'(so_valid1), 32'(e_v[1]));
    chk("so_first1", 32'(so_first1), 32'(e_f[1]));
    chk("so_last1",  32'(so_last1),  32'(e_l[1]));
    chk("in_ready1", 32'(in_ready1), 32'(m_n[1] < 2));
    chk("busy1",     32'(busy1),     32'(m_n[1] > 0));
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then check
  task automatic step();
    bit         acc;
    logic [7:0] cur;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        model_idle(i);
      end else begin
        acc = in_valid && (m_n[i] < 2);
        if (shift_en) begin
          if (m_n[i] > 0) begin
            cur     = m_w[i][0];
            e_so[i] = (i == 0) ? cur[7 - m_bp[i]] : cur[m_bp[i]];
            e_v[i]  = 1'b1;
            e_f[i]  = (m_bp[i] == 0);
            e_l[i]  = (m_bp[i] == 7);
            m_bp[i]++;
            if (m_bp[i] == 8) begin
              m_w[i][0] = m_w[i][1];
              m_n[i]--;
              m_bp[i] = 0;
            end
          end else begin
            e_so[i] = (i == 1);
            e_v[i]  = 1'b0;
            e_f[i]  = 1'b0;
            e_l[i]  = 1'b0;
          end
        end
        if (acc) begin
          m_w[i][m_n[i]] = in_data;
          m_n[i]++;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic se, input logic clr);
    in_valid = v;
    in_data  = d;
    shift_en = se;
    clear    = clr;
    step();
  endtask

  // Called 1 time unit after an edge: reset is pulled low mid-cycle and checked before any edge
  task automatic async_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_idle(0);
    model_idle(1);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int dens;
    model_idle(0);
    model_idle(1);
    #2;
    rst_n = 1'b0;
    #2;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single word, both bit orders
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h01, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Back-to-back words through the holding buffer
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 18; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Sparse bit ticks, load on a non-tick cycle
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) cyc(1'b0, 8'h00, (k % 4) == 3, 1'b0);

    // clear mid-word with a full buffer and a word offered in the same cycle
    cyc(1'b1, 8'hF0, 1'b1, 1'b0);
    cyc(1'b1, 8'h0F, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h81, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-word, then a fresh word
    cyc(1'b1, 8'hC3, 1'b1, 1'b0);
    cyc(1'b1, 8'h96, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    async_reset();
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with varying tick density
    for (int k = 0; k < 1200; k++) begin
      dens = (k / 200) % 3 == 0 ? 100 : ((k / 200) % 3 == 1 ? 50 : 20);
      if (k == 600) async_reset();
      cyc(($urandom % 100) < 60, 8'($urandom), ($urandom % 100) < dens, ($urandom % 100) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
